// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the bitwise/logic unit.
//   - op encodings (OP_AND .. OP_HDIST)
//   - FSM state encoding
//   - popcnt_width(): bits needed to hold a popcount of w bits
package bitwise_logic_pkg;

   localparam logic [2:0] OP_AND    = 3'b000;
   localparam logic [2:0] OP_OR     = 3'b001;
   localparam logic [2:0] OP_XOR    = 3'b010;
   localparam logic [2:0] OP_XNOR   = 3'b011;
   localparam logic [2:0] OP_NAND   = 3'b100;
   localparam logic [2:0] OP_NOR    = 3'b101;
   localparam logic [2:0] OP_PARITY = 3'b110;
   localparam logic [2:0] OP_HDIST  = 3'b111;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StReduce = 2'b01,
      StDone   = 2'b10
   } state_e;

   // A popcount of w bits ranges over 0..w, so it needs clog2(w+1) bits.
   function automatic int unsigned popcnt_width(int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one CHUNK-bit slice.
//   data_i   [CHUNK-1:0]             bits to count
//   count_o  [popcnt_width(CHUNK)-1:0] number of set bits in data_i
module popcount_chunk
   import bitwise_logic_pkg::*;
#(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0]               data_i,
   output logic [popcnt_width(CHUNK)-1:0] count_o
);

   localparam int unsigned CntW = popcnt_width(CHUNK);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < int'(CHUNK); i++) begin
         count_o = count_o + CntW'(data_i[i]);
      end
   end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Handshaked bitwise/logic unit.
//   Six bitwise ops complete in one cycle; PARITY and HDIST fold a^b CHUNK bits per cycle.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake; op, a, b sampled at accept only
//   out_valid/out_ready   result handshake; result, zero held while stalled
module bitwise_logic_unit
   import bitwise_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("bitwise_logic_unit: WIDTH must be a non-zero multiple of CHUNK");
   end

   localparam int unsigned N    = WIDTH / CHUNK;
   localparam int unsigned AccW = popcnt_width(WIDTH);
   localparam int unsigned PcW  = popcnt_width(CHUNK);
   localparam int unsigned CntW = popcnt_width(N);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [AccW-1:0]  acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             parity_q, parity_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic [WIDTH-1:0] bitwise_res;
   logic [PcW-1:0]   chunk_cnt;
   logic [AccW-1:0]  acc_sum;

   assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;
   assign accept    = in_valid & in_ready;

   // x_q shifts down one chunk per REDUCE cycle, so the active chunk is always
   // the low CHUNK bits; equivalent to indexing X by cnt*CHUNK.
   popcount_chunk #(
      .CHUNK (CHUNK)
   ) u_popcount (
      .data_i  (x_q[CHUNK-1:0]),
      .count_o (chunk_cnt)
   );

   always_comb begin
      unique case (op)
         OP_AND:  bitwise_res = a & b;
         OP_OR:   bitwise_res = a | b;
         OP_XOR:  bitwise_res = a ^ b;
         OP_XNOR: bitwise_res = ~(a ^ b);
         OP_NAND: bitwise_res = ~(a & b);
         OP_NOR:  bitwise_res = ~(a | b);
         default: bitwise_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      parity_d = parity_q;
      result_d = result_q;
      zero_d   = zero_q;
      acc_sum  = acc_q + AccW'(chunk_cnt);

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               if ((op == OP_PARITY) || (op == OP_HDIST)) begin
                  x_d      = a ^ b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  parity_d = (op == OP_PARITY);
                  state_d  = StReduce;
               end else begin
                  result_d = bitwise_res;
                  zero_d   = (bitwise_res == '0);
                  state_d  = StDone;
               end
            end else if ((state_q == StDone) && out_ready) begin
               state_d = StIdle;
            end
         end
         StReduce: begin
            x_d   = x_q >> CHUNK;
            acc_d = acc_sum;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(N - 1)) begin
               result_d = parity_q ? WIDTH'(acc_sum[0]) : WIDTH'(acc_sum);
               zero_d   = parity_q ? ~acc_sum[0] : (acc_sum == '0);
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         x_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         parity_q <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         parity_q <= parity_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule
